gd_sweep_ctrl: RTL and testbench

Sequencer for an AC group-delay frequency sweep on the two-port S-parameter measurement path.
- Steps a frequency code from a start value by a fixed step.
- Issues one measurement request per point to the S21 measurement engine and collects the returned S21 phase.
- Unwraps the phase and forms the per-point group-delay numerator, -Δphase.
- Streams results to a downstream consumer with backpressure. Division by 2π·Δf is done downstream.

---
 rtl/gd_sweep_if.sv | 29 ++
 rtl/gd_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gd_sweep_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gd_sweep_if.sv
// Measurement-engine and result-stream signals of the group-delay sweep sequencer.
// master = sequencer side, slave = measurement engine / downstream consumer side.
interface gd_sweep_if #(
  parameter int FREQ_W  = 32,
  parameter int PHASE_W = 16,
  parameter int UNW_W   = 32,
  parameter int IDX_W   = 10
);
  logic               meas_req;
  logic [FREQ_W-1:0]  meas_freq;
  logic               meas_ack;
  logic [PHASE_W-1:0] meas_phase;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic               out_first;
  logic [UNW_W-1:0]   out_unwrapped;
  logic [PHASE_W-1:0] out_delay;

  modport master (
    output meas_req, meas_freq, out_valid, out_idx, out_first, out_unwrapped, out_delay,
    input  meas_ack, meas_phase, out_ready
  );

  modport slave (
    input  meas_req, meas_freq, out_valid, out_idx, out_first, out_unwrapped, out_delay,
    output meas_ack, meas_phase, out_ready
  );
endinterface

// File: rtl/gd_sweep_ctrl.sv
// Group-delay sweep sequencer: steps frequency, requests S21 phase, unwraps it and streams -dphase.
// Optional pre-measurement settle phase enabled by defining GD_SETTLE_EN.
module gd_sweep_ctrl #(
  parameter int FREQ_W     = 32,
  parameter int PHASE_W    = 16,
  parameter int UNW_W      = 32,
  parameter int IDX_W      = 10,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FREQ_W-1:0] cfg_f_start,
  input  logic [FREQ_W-1:0] cfg_f_step,
  input  logic [IDX_W-1:0]  cfg_npts,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  gd_sweep_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_EMIT,
    ST_DONE
  } state_e;

`ifdef GD_SETTLE_EN
  localparam bit SETTLE_ON = (SETTLE_CYC > 0);
`else
  localparam bit SETTLE_ON = 1'b0;
`endif

  localparam state_e POINT_ENTRY = SETTLE_ON ? ST_SETTLE : ST_REQ;
  localparam int     CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int     EXT_W       = UNW_W - PHASE_W;
  localparam logic [PHASE_W-1:0] PH_MIN = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] PH_MAX = ~PH_MIN;

  state_e             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [IDX_W-1:0]   npts_q, npts_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [UNW_W-1:0]   unw_q, unw_d;
  logic [PHASE_W-1:0] prev_q, prev_d;
  logic [PHASE_W-1:0] delay_q, delay_d;
  logic               first_q, first_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Modular subtraction is the unwrap: the difference reinterpreted as signed is the shortest arc.
  logic [PHASE_W-1:0] dphi;
  assign dphi = bus.meas_phase - prev_q;

  function automatic logic [UNW_W-1:0] sext(input logic [PHASE_W-1:0] x);
    return {{EXT_W{x[PHASE_W-1]}}, x};
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d   = state_q;
    freq_d    = freq_q;
    step_d    = step_q;
    npts_d    = npts_q;
    idx_d     = idx_q;
    unw_d     = unw_q;
    prev_d    = prev_q;
    delay_d   = delay_q;
    first_d   = first_q;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_npts >= IDX_W'(2)) begin
            freq_d  = cfg_f_start;
            step_d  = cfg_f_step;
            npts_d  = cfg_npts;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = POINT_ENTRY;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.meas_ack) begin
          if (idx_q == '0) begin
            unw_d   = sext(bus.meas_phase);
            delay_d = '0;
            first_d = 1'b1;
          end else begin
            unw_d   = unw_q + sext(dphi);
            delay_d = (dphi == PH_MIN) ? PH_MAX : -dphi;
            first_d = 1'b0;
          end
          prev_d  = bus.meas_phase;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.out_ready) begin
          if (idx_q == npts_q - IDX_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            freq_d  = freq_q + step_q;
            cnt_d   = '0;
            state_d = POINT_ENTRY;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      freq_q    <= '0;
      step_q    <= '0;
      npts_q    <= '0;
      idx_q     <= '0;
      unw_q     <= '0;
      prev_q    <= '0;
      delay_q   <= '0;
      first_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      step_q    <= step_d;
      npts_q    <= npts_d;
      idx_q     <= idx_d;
      unw_q     <= unw_d;
      prev_q    <= prev_d;
      delay_q   <= delay_d;
      first_q   <= first_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // All outputs are decoded from registers, so abort and reset take effect without glitches.
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign cfg_err           = cfg_err_q;
  assign bus.meas_req      = (state_q == ST_REQ);
  assign bus.meas_freq     = freq_q;
  assign bus.out_valid     = (state_q == ST_EMIT);
  assign bus.out_idx       = idx_q;
  assign bus.out_first     = first_q;
  assign bus.out_unwrapped = unw_q;
  assign bus.out_delay     = delay_q;

endmodule

// File: tb/tb_gd_sweep_ctrl.sv
// Self-checking bench for gd_sweep_ctrl: directed and randomized sweeps against an arithmetic model.
// Expects SETTLE_CYC=4 on the DUT; settle latency is checked only when GD_SETTLE_EN is defined.
module tb_gd_sweep_ctrl;

  localparam int FREQ_W  = 32;
  localparam int PHASE_W = 16;
  localparam int UNW_W   = 32;
  localparam int IDX_W   = 10;
`ifdef GD_SETTLE_EN
  localparam int SETTLE_EXP = 4;
`else
  localparam int SETTLE_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [FREQ_W-1:0] cfg_f_start = '0;
  logic [FREQ_W-1:0] cfg_f_step = '0;
  logic [IDX_W-1:0]  cfg_npts = '0;
  logic              busy, done, cfg_err;

  gd_sweep_if #(.FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .UNW_W(UNW_W), .IDX_W(IDX_W)) bus ();

  gd_sweep_ctrl #(
    .FREQ_W(FREQ_W), .PHASE_W(PHASE_W), .UNW_W(UNW_W), .IDX_W(IDX_W), .SETTLE_CYC(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_f_start (cfg_f_start),
    .cfg_f_step  (cfg_f_step),
    .cfg_npts    (cfg_npts),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: integer phase arithmetic straight from the unwrap rules.
  longint        m_unw;
  int            m_prev;
  logic [31:0]   e_unw;
  logic [15:0]   e_delay;
  logic          e_first;

  logic [15:0] q_ph[$];
  int          q_ack[$];
  int          q_stall[$];
  bit          poke_start = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int s16(input logic [15:0] p);
    int v;
    v = int'(p);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_point(input int k, input logic [15:0] p);
    int ps, d;
    ps = s16(p);
    if (k == 0) begin
      m_unw   = longint'(ps);
      e_delay = 16'h0000;
      e_first = 1'b1;
    end else begin
      d = ps - m_prev;
      if (d > 32767) d -= 65536;
      else if (d < -32768) d += 65536;
      m_unw   = m_unw + longint'(d);
      e_delay = (d == -32768) ? 16'h7fff : 16'(-d);
      e_first = 1'b0;
    end
    m_prev = ps;
    e_unw  = m_unw[31:0];
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, done, cfg_err, bus.meas_req, bus.out_valid, bus.out_first}, 6'b0);
    check({tag, "_data"}, |{bus.meas_freq, bus.out_idx, bus.out_unwrapped, bus.out_delay}, 1'b0);
  endtask

  // Waits for meas_req after the point's frequency was loaded, returns cycles waited.
  task automatic wait_req(output int n);
    n = 0;
    while (!bus.meas_req && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_point(input int k, input logic [31:0] efreq, input logic [15:0] ph,
                          input int ack_dly, input int stall, input bit last);
    int n;
    logic [60:0] hold_exp;
    check("freq_loaded", bus.meas_freq, efreq);
    wait_req(n);
    check("req_latency", n, SETTLE_EXP);
    check("meas_freq", {bus.meas_req, bus.meas_freq}, {1'b1, efreq});
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("req_hold", {bus.meas_req, bus.meas_freq, bus.out_valid}, {1'b1, efreq, 1'b0});
    end
    bus.meas_ack   = 1'b1;
    bus.meas_phase = ph;
    tick();
    bus.meas_ack   = 1'b0;
    bus.meas_phase = 16'($urandom);
    model_point(k, ph);
    hold_exp = {1'b1, 1'b0, IDX_W'(k), e_first, e_unw, e_delay};
    check("emit", {bus.out_valid, bus.meas_req, bus.out_idx, bus.out_first,
                   bus.out_unwrapped, bus.out_delay}, 64'(hold_exp));
    for (int i = 0; i < stall; i++) begin
      if (i == 0 && poke_start) begin
        start    = 1'b1;
        cfg_npts = IDX_W'(1);
      end
      tick();
      start = 1'b0;
      check("emit_hold", {bus.out_valid, bus.meas_req, bus.out_idx, bus.out_first,
                          bus.out_unwrapped, bus.out_delay}, 64'(hold_exp));
      if (poke_start) check("start_ignored", {cfg_err, busy}, 2'b01);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 1'b0);
    if (last) begin
      check("done_pulse", {done, busy}, 2'b11);
      tick();
      check("idle_after", {done, busy, bus.meas_req}, 3'b000);
    end else begin
      check("no_done", done, 1'b0);
    end
  endtask

  task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fst, input int np);
    cfg_f_start = fs;
    cfg_f_step  = fst;
    cfg_npts    = IDX_W'(np);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start", {busy, cfg_err}, 2'b10);
  endtask

  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int np);
    start_sweep(fs, fst, np);
    for (int k = 0; k < np; k++)
      do_point(k, fs + 32'(k) * fst, q_ph[k], q_ack[k], q_stall[k], k == np - 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, np;
    bus.meas_ack   = 1'b0;
    bus.meas_phase = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Basic three-point sweep
    q_ph = '{16'h0000, 16'hF000, 16'hE000};
    q_ack = '{1, 1, 1};
    q_stall = '{0, 0, 0};
    run_sweep(32'd1000, 32'd10, 3);

    // Phase wrap across +/-pi with backpressure and an ignored start on idx1
    q_ph = '{16'h8100, 16'h7F00};
    q_ack = '{0, 0};
    q_stall = '{0, 5};
    poke_start = 1'b1;
    run_sweep(32'd5000, 32'd7, 2);
    poke_start = 1'b0;
    check("wrap_unw", e_unw, 32'hFFFF_7F00);

    // Half-turn steps: delay saturates at +max
    q_ph = '{16'h0000, 16'h8000, 16'h0000};
    q_ack = '{2, 0, 1};
    q_stall = '{1, 0, 2};
    run_sweep(32'hFFFF_FFF0, 32'h0000_0010, 3);

    // Config errors
    for (int i = 0; i < 2; i++) begin
      cfg_npts = IDX_W'(i);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("cfg_err_pulse", {cfg_err, busy}, 2'b10);
      tick();
      check("cfg_err_clear", {cfg_err, busy}, 2'b00);
    end

    // Abort during REQ of idx1 with a simultaneous ack
    q_ph = '{16'h1234};
    q_ack = '{0};
    q_stall = '{0};
    start_sweep(32'd200, 32'd3, 3);
    do_point(0, 32'd200, 16'h1234, 0, 0, 1'b0);
    wait_req(n);
    check("abort_req_seen", bus.meas_req, 1'b1);
    abort = 1'b1;
    bus.meas_ack = 1'b1;
    bus.meas_phase = 16'h4000;
    tick();
    abort = 1'b0;
    bus.meas_ack = 1'b0;
    check("abort_idle", {busy, bus.meas_req, bus.out_valid, done}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", {busy, bus.meas_req, bus.out_valid, done}, 4'b0000);
    end
    q_ph = '{16'h0100, 16'h0080, 16'hFF80};
    q_ack = '{0, 1, 0};
    q_stall = '{0, 1, 0};
    run_sweep(32'd200, 32'd3, 3);

    // Asynchronous reset mid-sweep with an outstanding ack
    q_ph = '{16'h0F00};
    start_sweep(32'd77, 32'd5, 4);
    do_point(0, 32'd77, 16'h0F00, 0, 0, 1'b0);
    wait_req(n);
    bus.meas_ack = 1'b1;
    bus.meas_phase = 16'h2222;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #1 rst_n = 1'b1;
    tick();
    check("ack_ignored", {busy, bus.meas_req, bus.out_valid}, 3'b000);
    bus.meas_ack = 1'b0;
    tick();
    check_all_zero("reset_idle");

    // Randomized sweeps
    for (int s = 0; s < 8; s++) begin
      np = (s == 0) ? 2 : int'($urandom_range(2, 6));
      q_ph.delete();
      q_ack.delete();
      q_stall.delete();
      for (int k = 0; k < np; k++) begin
        q_ph.push_back(16'($urandom));
        q_ack.push_back(int'($urandom_range(0, 3)));
        q_stall.push_back(int'($urandom_range(0, 3)));
      end
      run_sweep($urandom, $urandom, np);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
